// File: rtl/pfd_sync_lock.sv
// Clock-sampled phase-frequency detector: divides ref/fb, measures signed phase error
// in clk cycles and tracks lock with hysteresis and cycle-slip detection.
module pfd_sync_lock #(
  parameter int DIV_W        = 16,
  parameter int ERR_W        = 16,
  parameter int LOCK_TOL     = 4,
  parameter int LOCK_COUNT   = 32,
  parameter int UNLOCK_COUNT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    ref_in,
  input  logic                    fb_in,
  input  logic [DIV_W-1:0]        ref_div,
  input  logic [DIV_W-1:0]        fb_div,
  output logic                    up,
  output logic                    down,
  output logic signed [ERR_W-1:0] phase_err,
  output logic                    err_valid,
  output logic                    cycle_slip,
  output logic                    lock
);
  localparam int CNT_W  = ERR_W - 1;
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {PFD_IDLE, PFD_UP, PFD_DOWN} pfd_state_t;
  typedef enum logic {LK_UNLOCKED, LK_LOCKED} lock_state_t;

  logic [2:0]       ref_sync, fb_sync;
  logic             ref_pulse, fb_pulse;
  logic [DIV_W-1:0] ref_cnt, fb_cnt, ref_div_q, fb_div_q, ref_div_eff, fb_div_eff;
  logic             ref_ev, fb_ev;

  pfd_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc, close_mag;
  logic             close, close_neg, slip;

  lock_state_t       lk_state, lk_next;
  logic [GOOD_W-1:0] good_cnt, good_next;
  logic [BAD_W-1:0]  bad_cnt, bad_next;
  logic [ERR_W-1:0]  err_abs;
  logic              good;

  function automatic logic [DIV_W-1:0] nonzero_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  // Bit 0/1 form the synchroniser, bit 2 is the history used for rising-edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_sync  <= '0;
      fb_sync   <= '0;
      ref_pulse <= 1'b0;
      fb_pulse  <= 1'b0;
    end else begin
      ref_sync  <= {ref_sync[1:0], ref_in};
      fb_sync   <= {fb_sync[1:0], fb_in};
      ref_pulse <= enable & ref_sync[1] & ~ref_sync[2];
      fb_pulse  <= enable & fb_sync[1] & ~fb_sync[2];
    end
  end

  // At the start of a period the live ratio applies; mid-period the latched one does.
  always_comb begin
    ref_div_eff = (ref_cnt == '0) ? nonzero_div(ref_div) : ref_div_q;
    fb_div_eff  = (fb_cnt == '0) ? nonzero_div(fb_div) : fb_div_q;
    ref_ev      = ref_pulse && (ref_cnt == (ref_div_eff - DIV_W'(1)));
    fb_ev       = fb_pulse && (fb_cnt == (fb_div_eff - DIV_W'(1)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_cnt   <= '0;
      fb_cnt    <= '0;
      ref_div_q <= DIV_W'(1);
      fb_div_q  <= DIV_W'(1);
    end else if (!enable) begin
      ref_cnt <= '0;
      fb_cnt  <= '0;
    end else begin
      if (ref_pulse) begin
        if (ref_cnt == '0) ref_div_q <= ref_div_eff;
        ref_cnt <= ref_ev ? '0 : ref_cnt + DIV_W'(1);
      end
      if (fb_pulse) begin
        if (fb_cnt == '0) fb_div_q <= fb_div_eff;
        fb_cnt <= fb_ev ? '0 : fb_cnt + DIV_W'(1);
      end
    end
  end

  // The closing cycle itself is counted, so the error is the incremented count.
  always_comb begin
    cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    state_next = state;
    cnt_next   = cnt;
    close      = 1'b0;
    close_neg  = 1'b0;
    close_mag  = '0;
    slip       = 1'b0;
    case (state)
      PFD_IDLE: begin
        cnt_next = '0;
        if (ref_ev && fb_ev) close = 1'b1;
        else if (ref_ev) state_next = PFD_UP;
        else if (fb_ev) state_next = PFD_DOWN;
      end
      PFD_UP: begin
        cnt_next = cnt_inc;
        if (fb_ev) begin
          close     = 1'b1;
          close_mag = cnt_inc;
          if (ref_ev) cnt_next = '0;
          else state_next = PFD_IDLE;
        end else if (ref_ev) begin
          slip = 1'b1;
        end
      end
      PFD_DOWN: begin
        cnt_next = cnt_inc;
        if (ref_ev) begin
          close     = 1'b1;
          close_neg = 1'b1;
          close_mag = cnt_inc;
          if (fb_ev) cnt_next = '0;
          else state_next = PFD_IDLE;
        end else if (fb_ev) begin
          slip = 1'b1;
        end
      end
      default: state_next = PFD_IDLE;
    endcase
    if (!enable) begin
      state_next = PFD_IDLE;
      cnt_next   = '0;
      close      = 1'b0;
      slip       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= PFD_IDLE;
      cnt        <= '0;
      up         <= 1'b0;
      down       <= 1'b0;
      phase_err  <= '0;
      err_valid  <= 1'b0;
      cycle_slip <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      up         <= (state_next == PFD_UP);
      down       <= (state_next == PFD_DOWN);
      err_valid  <= close;
      cycle_slip <= slip;
      if (close)
        phase_err <= close_neg ? -$signed({1'b0, close_mag}) : $signed({1'b0, close_mag});
    end
  end

  // Lock hysteresis: LOCK_COUNT goods in a row to lock, UNLOCK_COUNT bads or a slip to drop.
  always_comb begin
    err_abs   = phase_err[ERR_W-1] ? -phase_err : phase_err;
    good      = (err_abs <= ERR_W'(LOCK_TOL));
    lk_next   = lk_state;
    good_next = good_cnt;
    bad_next  = bad_cnt;
    case (lk_state)
      LK_UNLOCKED: begin
        if (cycle_slip) begin
          good_next = '0;
        end else if (err_valid) begin
          if (!good) begin
            good_next = '0;
          end else if (good_cnt == GOOD_W'(LOCK_COUNT - 1)) begin
            lk_next   = LK_LOCKED;
            good_next = '0;
            bad_next  = '0;
          end else begin
            good_next = good_cnt + GOOD_W'(1);
          end
        end
      end
      LK_LOCKED: begin
        if (cycle_slip) begin
          lk_next   = LK_UNLOCKED;
          good_next = '0;
          bad_next  = '0;
        end else if (err_valid) begin
          if (good) begin
            bad_next = '0;
          end else if (bad_cnt == BAD_W'(UNLOCK_COUNT - 1)) begin
            lk_next   = LK_UNLOCKED;
            good_next = '0;
            bad_next  = '0;
          end else begin
            bad_next = bad_cnt + BAD_W'(1);
          end
        end
      end
      default: lk_next = LK_UNLOCKED;
    endcase
    if (!enable) begin
      lk_next   = LK_UNLOCKED;
      good_next = '0;
      bad_next  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lk_state <= LK_UNLOCKED;
      good_cnt <= '0;
      bad_cnt  <= '0;
      lock     <= 1'b0;
    end else begin
      lk_state <= lk_next;
      good_cnt <= good_next;
      bad_cnt  <= bad_next;
      lock     <= (lk_next == LK_LOCKED);
    end
  end

endmodule

// File: tb/tb_pfd_sync_lock.sv
// Scoreboard bench for pfd_sync_lock: expected phase errors are queued per stimulus
// window and popped on each err_valid; lock/slip/enable behaviour checked around them.
module tb_pfd_sync_lock;
  logic               clk = 1'b0;
  logic               reset, enable, ref_in, fb_in;
  logic [15:0]        ref_div, fb_div;
  logic               up, down, err_valid, cycle_slip, lock;
  logic signed [15:0] phase_err;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  int cyc = 0, ev_count = 0, last_ev_cyc = 0, slip_count = 0;
  int up_len = 0, down_len = 0, last_up_len = 0, last_down_len = 0;
  int up_ever = 0;
  int rise_cyc = -1, rise_ev = -1, rise_last_ev = -1;
  int fall_cyc = -1, fall_ev = -1, fall_last_ev = -1;
  logic lock_prev = 1'b0;
  int ev_mark, slip_mark;

  pfd_sync_lock dut (
    .clk(clk), .reset(reset), .enable(enable), .ref_in(ref_in), .fb_in(fb_in),
    .ref_div(ref_div), .fb_div(fb_div), .up(up), .down(down), .phase_err(phase_err),
    .err_valid(err_valid), .cycle_slip(cycle_slip), .lock(lock)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Each window pushes one expected error; ref/fb rise at first + m*per and stay high 2 clk.
  task automatic applyStimulus(input int windows, input int win_len,
                               input int ref_first, input int ref_per,
                               input int fb_first, input int fb_per,
                               input int exp_first, input int exp_rest);
    for (int w = 0; w < windows; w++) begin
      exp_q.push_back((w == 0) ? exp_first : exp_rest);
      for (int k = 0; k < win_len; k++) begin
        @(negedge clk);
        ref_in = (k >= ref_first) && (((k - ref_first) % ref_per) < 2);
        fb_in  = (k >= fb_first) && (((k - fb_first) % fb_per) < 2);
      end
    end
    @(negedge clk);
    ref_in = 1'b0;
    fb_in  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput(tag, exp_q.size(), 0);
  endtask

  task automatic waitUp(input string tag);
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (up) break;
    end
    checkOutput(tag, up, 1);
  endtask

  // Output monitor: scoreboard pop plus run-length and lock-edge bookkeeping.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (err_valid) begin
      ev_count++;
      last_ev_cyc = cyc;
      checkOutput("err_valid_expected", (exp_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0) checkOutput("phase_err", phase_err, exp_q.pop_front());
    end
    if (cycle_slip) slip_count++;
    if (up) begin
      up_len++;
      up_ever = 1;
    end else if (up_len != 0) begin
      last_up_len = up_len;
      up_len = 0;
    end
    if (down) begin
      down_len++;
    end else if (down_len != 0) begin
      last_down_len = down_len;
      down_len = 0;
    end
    if (lock && !lock_prev) begin
      rise_cyc = cyc;
      rise_ev = ev_count;
      rise_last_ev = last_ev_cyc;
    end
    if (!lock && lock_prev) begin
      fall_cyc = cyc;
      fall_ev = ev_count;
      fall_last_ev = last_ev_cyc;
    end
    lock_prev = lock;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; ref_in = 1'b0; fb_in = 1'b0;
    ref_div = 16'd1; fb_div = 16'd1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_up", up, 0);
    checkOutput("reset_down", down, 0);
    checkOutput("reset_err_valid", err_valid, 0);
    checkOutput("reset_slip", cycle_slip, 0);
    checkOutput("reset_lock", lock, 0);
    checkOutput("reset_phase_err", phase_err, 0);
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] fb leads ref by 3");
    up_ever = 0;
    applyStimulus(5, 20, 3, 20, 0, 20, -3, -3);
    drain("drain_fb_leads");
    checkOutput("down_len", last_down_len, 3);
    checkOutput("up_never", up_ever, 0);

    $display("[TB] ref leads fb by 5");
    applyStimulus(5, 20, 0, 20, 5, 20, 5, 5);
    drain("drain_ref_leads");
    checkOutput("up_len", last_up_len, 5);
    checkOutput("lock_low_bad", lock, 0);

    $display("[TB] aligned inputs, lock acquisition");
    ev_mark = ev_count;
    applyStimulus(34, 20, 0, 20, 0, 20, 0, 0);
    drain("drain_aligned");
    checkOutput("lock_rise_ev", rise_ev - ev_mark, 32);
    checkOutput("lock_rise_delay", rise_cyc - rise_last_ev, 1);
    checkOutput("lock_high", lock, 1);

    $display("[TB] fb shifted +10, lock loss");
    ev_mark = ev_count;
    applyStimulus(6, 20, 0, 20, 10, 20, 10, 10);
    drain("drain_shift10");
    checkOutput("lock_fall_ev", fall_ev - ev_mark, 4);
    checkOutput("lock_fall_delay", fall_cyc - fall_last_ev, 1);
    checkOutput("lock_low_shift", lock, 0);

    applyStimulus(33, 20, 0, 20, 0, 20, 0, 0);
    drain("drain_relock");
    checkOutput("relock", lock, 1);

    $display("[TB] ref at twice fb frequency, cycle slips");
    slip_mark = slip_count;
    applyStimulus(4, 20, 0, 10, 2, 20, 2, 12);
    drain("drain_slip");
    checkOutput("slip_count", slip_count - slip_mark, 3);
    checkOutput("lock_after_slip", lock, 0);
    checkOutput("up_before_disable", up, 1);
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("up_disabled", up, 0);
    checkOutput("phase_err_held", phase_err, 12);

    $display("[TB] ref_div=4 fb_div=2, aligned divided phases");
    ref_div = 16'd4;
    fb_div = 16'd2;
    @(negedge clk);
    enable = 1'b1;
    ev_mark = ev_count;
    applyStimulus(3, 40, 0, 10, 10, 20, 0, 0);
    drain("drain_div42");
    checkOutput("div42_events", ev_count - ev_mark, 3);

    $display("[TB] ref_div=0 behaves as 1");
    ref_div = 16'd0;
    fb_div = 16'd1;
    applyStimulus(3, 20, 0, 20, 2, 20, 2, 2);
    drain("drain_div0");

    $display("[TB] disable mid-UP");
    @(negedge clk);
    ref_in = 1'b1;
    waitUp("up_before_disable2");
    @(negedge clk);
    ref_in = 1'b0;
    enable = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("up_after_disable", up, 0);
    ev_mark = ev_count;
    @(negedge clk);
    fb_in = 1'b1;
    repeat (2) @(negedge clk);
    fb_in = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("no_ev_disabled", ev_count - ev_mark, 0);
    enable = 1'b1;
    applyStimulus(3, 20, 0, 20, 1, 20, 1, 1);
    drain("drain_reenable");
    checkOutput("reenable_events", ev_count - ev_mark, 3);

    $display("[TB] reset mid-measurement");
    @(negedge clk);
    ref_in = 1'b1;
    waitUp("up_before_reset");
    @(negedge clk);
    ref_in = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("reset_mid_up", up, 0);
    checkOutput("reset_mid_phase_err", phase_err, 0);
    checkOutput("reset_mid_lock", lock, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ev_mark = ev_count;
    fb_in = 1'b1;
    repeat (2) @(negedge clk);
    fb_in = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("no_ev_after_reset", ev_count - ev_mark, 0);
    checkOutput("queue_empty_end", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
